// File: rtl/gmii_rx_pkg.sv
// Shared constants, FSM state type and lane-mask helpers for the GMII RX deframer.
package gmii_rx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned LEN_W         = 16;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

    // Lane masks are zero-extended to 8 bits so one helper serves every LANES value.
    function automatic logic is_therm(input logic [7:0] dv);
        logic [7:0] dv_p1;
        dv_p1 = dv + 8'd1;
        return (dv & dv_p1) == 8'd0;
    endfunction

    function automatic logic [3:0] lane_count(input logic [7:0] dv);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(dv[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gmii_rx_stat_cnt.sv
// Saturating statistics counter with synchronous clear.
module gmii_rx_stat_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII-style RX deframer: strips preamble/SFD, streams frame bytes with one beat of
// lookahead so m_last lands on the true final beat, and keeps frame statistics.
module gmii_rx_deframer
    import gmii_rx_pkg::*;
#(
    parameter int unsigned LANES   = 1,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1522,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LANES-1:0]   rx_dv,
    input  logic [8*LANES-1:0] rxd,
    input  logic [LANES-1:0]   rx_er,
    output logic               m_valid,
    output logic [8*LANES-1:0] m_data,
    output logic [LANES-1:0]   m_keep,
    output logic               m_last,
    output logic               m_err,
    output logic [CNT_W-1:0]   stat_frames,
    output logic [CNT_W-1:0]   stat_err,
    output logic [CNT_W-1:0]   stat_align
);

    localparam int unsigned      DW    = 8 * LANES;
    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    rx_state_e        state, state_nx, pre_next;
    logic [LANES-1:0] dv_q, er_q;
    logic [DW-1:0]    d_q;
    logic [LEN_W-1:0] len_q, len_nx, len_sat;
    logic [LEN_W:0]   len_sum;
    logic             err_q, err_nx;
    logic             beat_er, q_therm, q_full, la_ok, data_viol, data_last;
    logic             found, pre_sfd_ok, pre_sfd_mis, pre_bad, align_inc;
    logic             valid_nx, last_nx, merr_nx;
    logic [DW-1:0]    data_nx;
    logic [LANES-1:0] keep_nx;

    // Beat classification on the registered beat; rx_* itself is the lookahead beat.
    always_comb begin
        beat_er   = |(er_q & dv_q);
        q_therm   = is_therm(8'(dv_q));
        q_full    = &dv_q;
        la_ok     = rx_dv[0] & is_therm(8'(rx_dv));
        data_viol = q_full & !is_therm(8'(rx_dv));
        data_last = !q_full | !rx_dv[0] | data_viol;
        len_sum   = {1'b0, len_q} + (LEN_W+1)'(lane_count(8'(dv_q)));
        len_sat   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

        found       = 1'b0;
        pre_sfd_ok  = 1'b0;
        pre_sfd_mis = 1'b0;
        pre_bad     = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (!found && dv_q[i] && d_q[8*i +: 8] != PREAMBLE_BYTE) begin
                found = 1'b1;
                if (d_q[8*i +: 8] == SFD_BYTE) begin
                    if (i == int'(LANES) - 1) pre_sfd_ok  = 1'b1;
                    else                      pre_sfd_mis = 1'b1;
                end else begin
                    pre_bad = 1'b1;
                end
            end
        end

        if (!q_therm || pre_bad || pre_sfd_mis) pre_next = DROP;
        else if (pre_sfd_ok)                    pre_next = la_ok ? DATA : DROP;
        else                                    pre_next = PREAMBLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // IDLE scans the first beat itself, so an SFD in the very first beat is not missed.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (dv_q[0]) state_nx = pre_next;
            PREAMBLE: state_nx = dv_q[0] ? pre_next : IDLE;
            DATA:     if (data_last) state_nx = data_viol ? DROP : IDLE;
            DROP:     if (!dv_q[0]) state_nx = IDLE;
        endcase
    end

    always_comb begin
        valid_nx  = 1'b0;
        data_nx   = '0;
        keep_nx   = '0;
        last_nx   = 1'b0;
        merr_nx   = 1'b0;
        len_nx    = len_q;
        err_nx    = err_q;
        align_inc = 1'b0;
        case (state)
            IDLE: if (dv_q[0]) begin
                err_nx    = beat_er;
                len_nx    = '0;
                align_inc = q_therm & pre_sfd_mis;
            end
            PREAMBLE: if (dv_q[0]) begin
                err_nx    = err_q | beat_er;
                len_nx    = '0;
                align_inc = q_therm & pre_sfd_mis;
            end
            DATA: begin
                valid_nx = 1'b1;
                data_nx  = d_q;
                keep_nx  = dv_q;
                last_nx  = data_last;
                len_nx   = len_sat;
                err_nx   = err_q | beat_er;
                merr_nx  = data_last & (err_nx | data_viol | (len_sat < MIN_L) | (len_sat > MAX_L));
            end
            DROP: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dv_q    <= '0;
            er_q    <= '0;
            d_q     <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            dv_q    <= rx_dv;
            er_q    <= rx_er;
            d_q     <= rxd;
            len_q   <= len_nx;
            err_q   <= err_nx;
            m_valid <= valid_nx;
            m_data  <= data_nx;
            m_keep  <= keep_nx;
            m_last  <= last_nx;
            m_err   <= merr_nx;
        end
    end

    // Frame outcome counters follow the registered m_last beat by one cycle.
    gmii_rx_stat_cnt #(.CNT_W(CNT_W)) u_cnt_frames (
        .clk   (clk),
        .clear (reset),
        .inc   (m_valid & m_last & ~m_err),
        .count (stat_frames)
    );

    gmii_rx_stat_cnt #(.CNT_W(CNT_W)) u_cnt_err (
        .clk   (clk),
        .clear (reset),
        .inc   (m_valid & m_last & m_err),
        .count (stat_err)
    );

    gmii_rx_stat_cnt #(.CNT_W(CNT_W)) u_cnt_align (
        .clk   (clk),
        .clear (reset),
        .inc   (align_inc),
        .count (stat_align)
    );

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Randomized bench for gmii_rx_deframer (4 lanes): frames are built as byte lists and
// the expected output stream and statistics are derived from frame-level rules.
module tb_gmii_rx_deframer;

    localparam int LANES   = 4;
    localparam int CNT_W   = 4;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               reset;
    logic [LANES-1:0]   rx_dv;
    logic [8*LANES-1:0] rxd;
    logic [LANES-1:0]   rx_er;
    logic               m_valid;
    logic [8*LANES-1:0] m_data;
    logic [LANES-1:0]   m_keep;
    logic               m_last;
    logic               m_err;
    logic [CNT_W-1:0]   stat_frames;
    logic [CNT_W-1:0]   stat_err;
    logic [CNT_W-1:0]   stat_align;

    int n_checks = 0;
    int n_errors = 0;
    int mdl_frames = 0;
    int mdl_err = 0;
    int mdl_align = 0;

    logic [7:0] exp_byte_q[$];
    int         exp_len_q[$];
    logic       exp_err_q[$];
    logic [7:0] got_q[$];
    int         keep_bad = 0;
    int         mon_n;
    int         mon_mism;
    logic       mon_e;
    logic [7:0] mon_b;

    gmii_rx_deframer #(
        .LANES   (LANES),
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_dv       (rx_dv),
        .rxd         (rxd),
        .rx_er       (rx_er),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_keep      (m_keep),
        .m_last      (m_last),
        .m_err       (m_err),
        .stat_frames (stat_frames),
        .stat_err    (stat_err),
        .stat_align  (stat_align)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic int keep_for(input int n);
        int rem;
        rem = n % LANES;
        return (rem == 0) ? (1 << LANES) - 1 : (1 << rem) - 1;
    endfunction

    // Reassemble output frames and compare each against the next expected frame.
    always @(negedge clk) begin
        if (reset) begin
            got_q.delete();
            keep_bad = 0;
        end else if (m_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (m_keep[i]) got_q.push_back(m_data[8*i +: 8]);
            end
            if (!m_last) begin
                if (m_keep != LANES'((1 << LANES) - 1)) keep_bad++;
            end else begin
                chk("frame_expected", int'(exp_len_q.size() > 0), 1);
                if (exp_len_q.size() > 0) begin
                    mon_n = exp_len_q.pop_front();
                    mon_e = exp_err_q.pop_front();
                    mon_mism = 0;
                    for (int i = 0; i < mon_n; i++) begin
                        mon_b = exp_byte_q.pop_front();
                        if (i >= got_q.size() || got_q[i] !== mon_b) mon_mism++;
                    end
                    chk("frame_len", got_q.size(), mon_n);
                    chk("frame_data_mismatches", mon_mism, 0);
                    chk("frame_err", int'(m_err), int'(mon_e));
                    chk("last_keep", int'(m_keep), keep_for(mon_n));
                    chk("mid_keep_not_full", keep_bad, 0);
                end
                keep_bad = 0;
                got_q.delete();
            end
        end
    end

    task automatic check_stats(input string tag);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk({tag, "_stat_frames"}, int'(stat_frames), mdl_frames);
        chk({tag, "_stat_err"}, int'(stat_err), mdl_err);
        chk({tag, "_stat_align"}, int'(stat_align), mdl_align);
        chk({tag, "_pending_frames"}, exp_len_q.size(), 0);
    endtask

    // Drive one frame (pre_n preamble bytes, SFD, len payload bytes) and register its expectation.
    task automatic run_frame(input int pre_n, input int len, input int er_pos, input int bad_pos,
                             input int viol_beat, input int rst_beat, input int gap);
        logic [7:0]         wb[$];
        logic               we[$];
        logic [LANES-1:0]   dv, er;
        logic [8*LANES-1:0] d;
        int total, nbeats, first_pl, n_out, idx;
        logic exp_e;

        for (int i = 0; i < pre_n; i++) wb.push_back((i == bad_pos) ? 8'h00 : 8'h55);
        wb.push_back(8'hD5);
        for (int i = 0; i < len; i++) wb.push_back(8'($urandom));
        total = wb.size();
        for (int i = 0; i < total; i++) we.push_back(i == er_pos);
        nbeats   = (total + LANES - 1) / LANES;
        first_pl = (pre_n + 1) / LANES;

        if (rst_beat < 0 && bad_pos < 0) begin
            n_out = 0;
            exp_e = 1'b0;
            if ((pre_n % LANES) != LANES - 1) begin
                mdl_align = sat(mdl_align);
            end else if (viol_beat >= 0) begin
                n_out = LANES * (viol_beat - first_pl);
                exp_e = 1'b1;
            end else begin
                n_out = len;
                exp_e = (len < MIN_LEN) || (len > MAX_LEN) || (er_pos >= 0);
            end
            if (n_out > 0) begin
                exp_len_q.push_back(n_out);
                exp_err_q.push_back(exp_e);
                for (int i = 0; i < n_out; i++) exp_byte_q.push_back(wb[pre_n + 1 + i]);
                if (exp_e) mdl_err = sat(mdl_err);
                else       mdl_frames = sat(mdl_frames);
            end
        end

        for (int b = 0; b < nbeats; b++) begin
            @(posedge clk);
            #1;
            dv = '0;
            d  = $urandom;
            er = LANES'($urandom);
            for (int l = 0; l < LANES; l++) begin
                idx = b * LANES + l;
                if (idx < total) begin
                    dv[l]       = 1'b1;
                    d[8*l +: 8] = wb[idx];
                    er[l]       = we[idx];
                end
            end
            if (b == viol_beat) dv = LANES'(4'b1011);
            if (rst_beat >= 0 && b > rst_beat) d = '0;
            reset = (b == rst_beat);
            rx_dv = dv;
            rxd   = d;
            rx_er = er;
            if (rst_beat >= 0 && b == rst_beat + 1) begin
                @(negedge clk);
                mdl_frames = 0;
                mdl_err    = 0;
                mdl_align  = 0;
                chk("rst_m_valid", int'(m_valid), 0);
                chk("rst_m_data", int'(m_data), 0);
                chk("rst_m_last", int'(m_last), 0);
                chk("rst_stat_frames", int'(stat_frames), mdl_frames);
                chk("rst_stat_err", int'(stat_err), mdl_err);
            end
        end
        reset = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
            rx_dv = '0;
            rxd   = $urandom;
            rx_er = LANES'($urandom);
        end
    endtask

    initial begin
        int pre, len, er_pos, bad_pos, viol, nb, fp, k;

        reset = 1'b1;
        rx_dv = '0;
        rxd   = '0;
        rx_er = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_data", int'(m_data), 0);
        chk("reset_m_keep", int'(m_keep), 0);
        chk("reset_m_last", int'(m_last), 0);
        chk("reset_m_err", int'(m_err), 0);
        chk("reset_stat_frames", int'(stat_frames), 0);
        chk("reset_stat_err", int'(stat_err), 0);
        chk("reset_stat_align", int'(stat_align), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed boundaries: nominal, partial last beat, misaligned SFD, runt/oversize limits.
        run_frame(7, 64, -1, -1, -1, -1, 3);
        check_stats("first_frame");
        run_frame(7, 66, -1, -1, -1, -1, 2);
        run_frame(5, 64, -1, -1, -1, -1, 2);
        run_frame(7, 70, -1, -1, -1, -1, 2);
        check_stats("align");
        run_frame(7, 63, -1, -1, -1, -1, 1);
        run_frame(7, 1523, -1, -1, -1, -1, 1);
        run_frame(7, 1522, -1, -1, -1, -1, 1);
        run_frame(3, 64, -1, -1, -1, -1, 1);
        run_frame(7, 100, 8 + 19, -1, -1, -1, 2);
        run_frame(7, 80, -1, 2, -1, -1, 2);
        run_frame(7, 64, -1, -1, 6, -1, 2);
        run_frame(7, 64, -1, -1, 2, -1, 2);
        check_stats("directed");

        // Synchronous reset in the middle of DATA, then a clean frame.
        run_frame(7, 100, -1, -1, -1, 10, 3);
        run_frame(7, 80, -1, -1, -1, -1, 2);
        check_stats("after_reset");

        for (int f = 0; f < 48; f++) begin
            k       = $urandom_range(0, 9);
            pre     = 4 * $urandom_range(0, 2) + 3;
            len     = ($urandom_range(0, 7) == 0) ? $urandom_range(1500, 1530) : $urandom_range(1, 150);
            er_pos  = -1;
            bad_pos = -1;
            viol    = -1;
            if (k == 0) pre = 4 * $urandom_range(0, 2) + $urandom_range(0, 2);
            if (k == 1) er_pos = $urandom_range(0, pre + len);
            if (k == 2) bad_pos = $urandom_range(0, pre - 1);
            if (k == 3) begin
                nb   = (pre + 1 + len + LANES - 1) / LANES;
                fp   = (pre + 1) / LANES;
                viol = (nb - 1 > fp) ? $urandom_range(fp, nb - 1) : -1;
            end
            run_frame(pre, len, er_pos, bad_pos, viol, -1, $urandom_range(1, 3));
            if (f % 12 == 11) check_stats("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
